// File: rtl/xnor_ripple_carry_adder16.sv
// Unsigned ripple-carry adder built from XNOR-based full-adder cells,
// with a registered WIDTH+1-bit result (carry-out in the MSB).
module xnor_ripple_carry_adder16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  output logic [WIDTH:0]   result_o
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] sum;

  // Ripple the carry through one XNOR full-adder cell per bit, LSB first.
  always_comb begin
    carry    = '0;
    prop     = '0;
    sum      = '0;
    carry[0] = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      // prop is high when both operand bits agree; the carry is then that bit,
      // otherwise the incoming carry passes straight through.
      prop[i]    = ~(add1_i[i] ^ add2_i[i]);
      sum[i]     = ~(prop[i] ^ carry[i]);
      carry[i+1] = prop[i] ? add1_i[i] : carry[i];
    end
  end

  // Output register: one-cycle latency, cleared immediately by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_o <= '0;
    end else begin
      result_o <= {carry[WIDTH], sum};
    end
  end

endmodule

// File: tb/tb_xnor_ripple_carry_adder16.sv
// Scoreboard bench for xnor_ripple_carry_adder16: expected sums are queued
// when operands are driven and compared one edge later.
module tb_xnor_ripple_carry_adder16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [16:0] result;

  int checks   = 0;
  int failures = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  xnor_ripple_carry_adder16 #(.WIDTH(16)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .add1_i   (op_a),
    .add2_i   (op_b),
    .result_o (result)
  );

  task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Present an operand pair and queue the sum it must produce.
  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [16:0] exp);
    op_a = x;
    op_b = y;
    exp_q.push_back(exp);
  endtask

  // Let one edge capture, then compare against the oldest queued sum.
  task automatic step_and_check(input string tag);
    logic [16:0] exp;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got %05h expected <queue empty>", tag, result);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, result, exp);
    end
  endtask

  logic [15:0] dir_a [14];
  logic [15:0] dir_b [14];
  logic [16:0] dir_e [14];

  initial begin
    dir_a = '{16'h0000, 16'h29AF, 16'hABCD, 16'h0000, 16'h0000,
              16'h8943, 16'h8051, 16'hFFFF, 16'h5555, 16'hFFFF,
              16'h4482, 16'hFADC, 16'h1111, 16'h1100};
    dir_b = '{16'h0000, 16'h7A1B, 16'h0000, 16'h1234, 16'h0001,
              16'hFFFF, 16'h8086, 16'hFFFF, 16'hAAAA, 16'h0001,
              16'h3BCD, 16'h00DC, 16'hEEAA, 16'h1111};
    dir_e = '{17'h00000, 17'h0A3CA, 17'h0ABCD, 17'h01234, 17'h00001,
              17'h18942, 17'h100D7, 17'h1FFFE, 17'h0FFFF, 17'h10000,
              17'h0804F, 17'h0FBB8, 17'h0FFBB, 17'h02211};

    // Reset held with live operands: output stays zero across edges.
    rst_n = 1'b1;
    op_a  = 16'hABCD;
    op_b  = 16'h1234;
    #1 rst_n = 1'b0;
    #1 check_eq("reset_async", result, 17'h00000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_eq("reset_hold", result, 17'h00000);
    end
    @(negedge clk) rst_n = 1'b1;
    drive(16'hABCD, 16'h1234, 17'h0BE01);
    step_and_check("reset_release");

    // Directed patterns, back to back, one per cycle.
    for (int i = 0; i < 14; i++) begin
      drive(dir_a[i], dir_b[i], dir_e[i]);
      step_and_check($sformatf("directed_%0d", i));
    end

    // Mid-cycle operand change: only the value present at the edge counts.
    op_a = 16'h1111;
    op_b = 16'h2222;
    #2;
    drive(16'h0F0F, 16'h0101, 17'h01010);
    step_and_check("mid_cycle_change");

    // Reset asserted between edges discards the in-flight sum.
    drive(16'h1234, 16'h4321, 17'h05555);
    step_and_check("pre_reset");
    drive(16'hFFFF, 16'hFFFF, 17'h1FFFE);
    #2 rst_n = 1'b0;
    #1 check_eq("midstream_reset_async", result, 17'h00000);
    exp_q.delete();
    @(posedge clk);
    #1 check_eq("midstream_reset_hold", result, 17'h00000);
    @(negedge clk) rst_n = 1'b1;

    // Random pairs against an arithmetic reference.
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] x;
      logic [15:0] y;
      x = 16'($urandom);
      y = 16'($urandom);
      drive(x, y, {1'b0, x} + {1'b0, y});
      step_and_check("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
